picomem_responder: RTL
======================

PICOMEM_RESPONDER -- requirements
Module: picomem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit RAM words, mapped from byte address 0 upward.
REQ-002 Parameter WAIT_CYCLES, default 0: extra wait states inserted before each response (0..15).
REQ-003 Parameter MMIO_BASE, default 32'h1000_0000: base byte address of the MMIO register window.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 mem_valid  input  1  initiator request; held high until mem_ready is seen.
REQ-007 mem_instr  input  1  instruction fetch qualifier; no effect on behaviour.
REQ-008 mem_addr  input  32  byte address; bits [1:0] are ignored.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_wstrb  input  4  byte write strobes; 4'b0000 marks a read.
REQ-011 mem_ready  output  1  one-cycle response pulse.
REQ-012 mem_rdata  output  32  read data, valid while mem_ready=1.
REQ-013 gpio_out  output  32  value of the GPIO register.
REQ-014 bus_err  output  1  one-cycle pulse that marks an unmapped access.

Function
REQ-015 The FSM SHALL have three states:
- IDLE -> WAIT when mem_valid=1, mem_ready=0 and WAIT_CYCLES>0.
- IDLE -> RESP when mem_valid=1, mem_ready=0 and WAIT_CYCLES=0.
- WAIT -> RESP after WAIT_CYCLES cycles.
- RESP -> IDLE unconditionally.
REQ-016 The block SHALL register mem_addr, mem_wdata and mem_wstrb on the IDLE accept edge and use only these captured values for the rest of the transaction.
REQ-017 mem_ready SHALL be 1 only in RESP, for exactly one cycle per transaction; latency is 1+WAIT_CYCLES cycles from the accept edge.
REQ-018 While mem_ready=1 the block SHALL NOT accept a new request; a new request can be accepted at the earliest in the cycle after the RESP cycle.
REQ-019 RAM hit (addr < MEM_WORDS*4):
- Read: mem_rdata = RAM[addr>>2].
- Write: each byte with its strobe set SHALL update on the edge that enters RESP; unstrobed bytes are unchanged.
REQ-020 For every write transaction, mem_rdata SHALL be 32'h0.
REQ-021 MMIO_BASE+0, GPIO: read/write with byte strobes; gpio_out reflects the update in the same cycle mem_ready=1.
REQ-022 MMIO_BASE+4, CYCLE: read-only free-running 32-bit counter, incremented every clock, wraps 32'hFFFF_FFFF -> 0; a read returns the value at the accept edge; writes are ignored without error.
REQ-023 MMIO_BASE+8, XACT: read-only count of completed transactions, wraps at 2^32; the count increments on each RESP cycle and a read returns the pre-increment value.
REQ-024 Unmapped address: mem_ready SHALL still pulse (no hang); mem_rdata=0; bus_err=1 in the same cycle; no state other than XACT changes.
REQ-025 If mem_valid falls while in WAIT, the FSM SHALL return to IDLE without mem_ready, without any write, and without an XACT increment.

Reset
REQ-026 While resetn=0, the block SHALL force the following immediately, independent of clk: state=IDLE, mem_ready=0, mem_rdata=0, bus_err=0, gpio_out=0, CYCLE=0, XACT=0, wait counter=0.
REQ-027 Reset SHALL NOT initialise RAM contents.
REQ-028 Reset asserted mid-transaction SHALL abort the transaction with no write committed; the first request after resetn rises is handled normally.

Verification
REQ-029 WAIT_CYCLES=0: write 0x3FC data 0x0000_0001 strb 1111, then read 0x3FC -> each mem_ready one cycle after accept; read returns 0x0000_0001; XACT read returns 2.
REQ-030 Byte strobes: RAM[4]=0x1122_3344, write 0xAABB_CCDD with strb 0101 -> read returns 0x11BB_33DD.
REQ-031 WAIT_CYCLES=3: read 0x0 -> mem_ready exactly 4 cycles after accept; drop mem_valid after 1 wait cycle -> no mem_ready, XACT unchanged.
REQ-032 Unmapped read 0x2000_0000 -> mem_ready with bus_err=1 in the same cycle, rdata 0; a write to CYCLE causes no error and no change to the counter.
REQ-033 GPIO: write 0xDEAD_BEEF strb 1100 -> gpio_out=0xDEAD_0000; then assert resetn=0 during a pending RAM write -> gpio_out=0, target RAM word unchanged.
REQ-034 CYCLE wrap: force the counter to 0xFFFF_FFFE -> two clocks later the counter reads 0x0000_0000.

Source files
------------

// File: rtl/picomem_responder_if.sv
// PicoRV32-style native memory bus between one initiator and one responder.
// Handshake: the initiator raises mem_valid with addr/wdata/wstrb stable and holds it
// until it sees mem_ready=1; mem_ready is a one-cycle pulse and mem_rdata is valid only then.
interface picomem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/picomem_responder.sv
// Memory/MMIO responder for a PicoRV32-style bus: byte-strobed RAM, a GPIO register,
// a free-running cycle counter and a completed-transaction counter, with optional wait states.
module picomem_responder #(
  parameter int          MEM_WORDS   = 256,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
  input  logic                clk,
  input  logic                resetn,
  picomem_responder_if.slave  bus,
  output logic [31:0]         gpio_out,
  output logic                bus_err,
  output logic [1:0]          state_dbg
);

  localparam int          AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES  = 33'(MEM_WORDS) << 2;
  localparam logic [3:0]  WAIT_LAST  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [29:0] GPIO_WORD  = MMIO_BASE[31:2];
  localparam logic [29:0] CYCLE_WORD = GPIO_WORD + 30'd1;
  localparam logic [29:0] XACT_WORD  = GPIO_WORD + 30'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] a_addr, a_wdata, cyc_snap;
  logic [3:0]  a_wstrb;
  logic        ready_q, err_q;
  logic [31:0] rdata_q, gpio_q, cycle_cnt, xact_cnt;
  logic [31:0] ram [MEM_WORDS];

  logic          accept, enter_resp, is_wr;
  logic          hit_ram, hit_gpio, hit_cyc, hit_xact;
  logic [31:0]   r_addr, r_wdata, r_cycle, resp_rdata, gpio_next;
  logic [3:0]    r_wstrb;
  logic [AW-1:0] ram_idx;
  logic          unused_instr;

  assign unused_instr  = bus.mem_instr;
  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign gpio_out      = gpio_q;
  assign bus_err       = err_q;
  assign state_dbg     = state;

  assign accept     = (state == S_IDLE) && bus.mem_valid && !ready_q;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) ||
                      ((state == S_WAIT) && bus.mem_valid && (wait_cnt == WAIT_LAST));

  // With zero wait states the response is built on the accept edge itself, so the
  // live bus values stand in for the captured ones that are not yet registered.
  always_comb begin
    r_addr  = a_addr;
    r_wdata = a_wdata;
    r_wstrb = a_wstrb;
    r_cycle = cyc_snap;
    if (state == S_IDLE) begin
      r_addr  = bus.mem_addr;
      r_wdata = bus.mem_wdata;
      r_wstrb = bus.mem_wstrb;
      r_cycle = cycle_cnt;
    end
  end

  assign is_wr    = |r_wstrb;
  assign hit_ram  = {1'b0, r_addr} < RAM_BYTES;
  assign hit_gpio = r_addr[31:2] == GPIO_WORD;
  assign hit_cyc  = r_addr[31:2] == CYCLE_WORD;
  assign hit_xact = r_addr[31:2] == XACT_WORD;
  assign ram_idx  = r_addr[AW+1:2];

  always_comb begin
    resp_rdata = 32'h0;
    if (!is_wr) begin
      if (hit_ram)       resp_rdata = ram[ram_idx];
      else if (hit_gpio) resp_rdata = gpio_q;
      else if (hit_cyc)  resp_rdata = r_cycle;
      else if (hit_xact) resp_rdata = xact_cnt;
    end
  end

  always_comb begin
    gpio_next = gpio_q;
    for (int b = 0; b < 4; b++)
      if (r_wstrb[b]) gpio_next[8*b +: 8] = r_wdata[8*b +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      a_addr    <= 32'h0;
      a_wdata   <= 32'h0;
      a_wstrb   <= 4'h0;
      cyc_snap  <= 32'h0;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      gpio_q    <= 32'h0;
      cycle_cnt <= 32'h0;
      xact_cnt  <= 32'h0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      ready_q   <= 1'b0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;

      case (state)
        S_IDLE: if (accept) begin
          a_addr   <= bus.mem_addr;
          a_wdata  <= bus.mem_wdata;
          a_wstrb  <= bus.mem_wstrb;
          cyc_snap <= cycle_cnt;
          wait_cnt <= 4'd0;
          state    <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
        S_WAIT: begin
          if (!bus.mem_valid)              state <= S_IDLE;
          else if (wait_cnt == WAIT_LAST)  state <= S_RESP;
          else                             wait_cnt <= wait_cnt + 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (enter_resp) begin
        ready_q  <= 1'b1;
        rdata_q  <= resp_rdata;
        err_q    <= !(hit_ram || hit_gpio || hit_cyc || hit_xact);
        xact_cnt <= xact_cnt + 32'd1;
        if (hit_gpio && is_wr) gpio_q <= gpio_next;
      end
    end
  end

  // RAM has no reset; gating on resetn keeps an aborted transaction from committing.
  always_ff @(posedge clk) begin
    if (resetn && enter_resp && hit_ram && is_wr)
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) ram[ram_idx][8*b +: 8] <= r_wdata[8*b +: 8];
  end

endmodule
